// File: rtl/tpu_seq_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
// Defines the job state machine encoding and the compute-phase decodes.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADC,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

  localparam int LANE_MAX = 32;

  // Diagonal skew: lane i sees data from step i through step i+dim-1.
  function automatic int comp_len(input int dim);
    return 3 * dim - 2;
  endfunction

  function automatic logic [LANE_MAX-1:0] lane_mask(input int k, input int dim);
    logic [LANE_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < LANE_MAX; i++) begin
      if (i < dim && i <= k && k <= i + dim - 1) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/tpu_seq_drain.sv
// Result-row drain counter: advances on vld & rdy, wraps to 0 after the last row.
// last pulses combinationally on the handshake of row DIM-1; rdy low holds the row.
module tpu_seq_drain #(
  parameter int DIM   = 4,
  parameter int ROW_W = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic             rdy,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);

  logic [ROW_W-1:0] row_q;
  logic             hs;

  assign hs   = vld & rdy;
  assign last = hs && (row_q == LAST_ROW);
  assign row  = row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
    end else if (hs) begin
      row_q <= last ? '0 : row_q + ROW_W'(1);
    end
  end

endmodule

// File: rtl/tpu_array_seq.sv
// Job sequencer for a DIM x DIM systolic MAC array: LOADC -> COMPUTE -> DRAIN -> DONE.
// stall freezes LOADC/COMPUTE; TPU_SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module tpu_array_seq
  import tpu_seq_pkg::*;
#(
  parameter int DIM    = 4,
  parameter int STEP_W = $clog2(3 * DIM),
  parameter int ROW_W  = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr_c,
  input  logic              stall,
  output logic              mac_en,
  output logic              mac_wren,
  output logic [ROW_W-1:0]  c_row,
  output logic              c_zero,
  output logic [STEP_W-1:0] feed_step,
  output logic [DIM-1:0]    lane_vld,
  output logic [ROW_W-1:0]  res_row,
  output logic              res_vld,
  input  logic              res_rdy,
  output logic              busy,
  output logic              done
`ifdef TPU_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(DIM - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(comp_len(DIM) - 1);

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    c_row_q, c_row_d;
  logic [STEP_W-1:0]   k_q, k_d;
  logic                c_zero_q, c_zero_d;
  logic [DIM-1:0]      lane_vld_q, lane_vld_d;
  logic                res_vld_q, busy_q, done_q;
  logic                accept, drain_last;
  logic [LANE_MAX-1:0] mask_full;
  logic                unused_mask;

  always_comb begin
    state_d  = state_q;
    c_row_d  = c_row_q;
    k_d      = k_q;
    c_zero_d = c_zero_q;
    mac_en   = 1'b0;
    mac_wren = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          c_zero_d = clr_c;
          state_d  = LOADC;
        end
      end
      LOADC: begin
        if (!stall) begin
          mac_en   = 1'b1;
          mac_wren = 1'b1;
          if (c_row_q == LAST_ROW) begin
            c_row_d = '0;
            state_d = COMPUTE;
          end else begin
            c_row_d = c_row_q + ROW_W'(1);
          end
        end
      end
      COMPUTE: begin
        if (!stall) begin
          mac_en = 1'b1;
          if (k_q == LAST_STEP) begin
            k_d     = '0;
            state_d = DRAIN;
          end else begin
            k_d = k_q + STEP_W'(1);
          end
        end
      end
      DRAIN:   if (drain_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane mask is registered alongside the step it describes.
  always_comb begin
    mask_full  = lane_mask(int'(k_d), DIM);
    lane_vld_d = (state_d == COMPUTE) ? mask_full[DIM-1:0] : '0;
  end

  assign unused_mask = ^mask_full[LANE_MAX-1:DIM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      c_row_q    <= '0;
      k_q        <= '0;
      c_zero_q   <= 1'b0;
      lane_vld_q <= '0;
      res_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_row_q    <= c_row_d;
      k_q        <= k_d;
      c_zero_q   <= c_zero_d;
      lane_vld_q <= lane_vld_d;
      res_vld_q  <= (state_d == DRAIN);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  tpu_seq_drain #(
    .DIM   (DIM),
    .ROW_W (ROW_W)
  ) u_drain (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (res_vld_q),
    .rdy   (res_rdy),
    .row   (res_row),
    .last  (drain_last)
  );

  assign c_row     = c_row_q;
  assign c_zero    = c_zero_q;
  assign feed_step = k_q;
  assign lane_vld  = lane_vld_q;
  assign res_vld   = res_vld_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef TPU_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (accept) begin
      stall_cnt_q <= '0;
    end else if ((state_q == LOADC || state_q == COMPUTE) && stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
